// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader: FSM states,
// byte-lane positions and decoding of the leading word-count byte.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef struct packed {
    logic       legal;
    logic [8:0] n;
  } count_t;

  // A count byte of zero stands for the full RAM depth.
  function automatic count_t decode_count(input logic [7:0] b, input int depth_log2);
    count_t     r;
    logic [8:0] full;
    full    = 9'(1 << depth_log2);
    r.n     = (b == 8'd0) ? full : {1'b0, b};
    r.legal = (r.n <= full);
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: one synchronous write port, one combinational read port
// for instruction fetch. Reads of the word being written see the old data.
module imem_loader_ram #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] a,
  output logic [31:0]           rd
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // NOTE: memory arrays are deliberately not reset; contents survive a reset
  // and a reset loop over the array would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd = mem[a];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, big-endian byte stream into the instruction RAM
// and holds the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_LOG2     = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DEPTH_LOG2-1:0] a,
  output logic [31:0]           rd,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err,
  output logic [DEPTH_LOG2:0]   words_loaded
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WLW = DEPTH_LOG2 + 1;

  state_t                state, state_next;
  logic [1:0]            lane;
  logic [23:0]           hold;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [8:0]            n_words;
  logic [TW-1:0]         tcnt;

  count_t                dec;
  logic                  accept;
  logic                  we;
  logic [WLW-1:0]        wl_inc;
  logic [TW-1:0]         tcnt_inc;
  logic                  last_word;

  assign dec       = decode_count(in_data, DEPTH_LOG2);
  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign we        = (state == LOAD) && accept && (lane == LANE_3);
  assign wl_inc    = words_loaded + WLW'(1);
  assign tcnt_inc  = tcnt + TW'(1);
  assign last_word = (9'(wl_inc) == n_words);

  assign cpu_reset = (state != RUN);
  assign done      = (state == RUN);
  assign err       = (state == ERROR);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = dec.legal ? LOAD : ERROR;
      LOAD: begin
        if (we && last_word)                          state_next = RUN;
        else if (!accept && tcnt_inc == TW'(TIMEOUT_CYCLES)) state_next = ERROR;
      end
      default: state_next = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lane         <= LANE_0;
      hold         <= '0;
      waddr        <= '0;
      n_words      <= '0;
      tcnt         <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            n_words <= dec.n;
            lane    <= LANE_0;
            tcnt    <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            tcnt <= '0;
            lane <= lane + 2'd1;
            case (lane)
              LANE_0:  hold[23:16] <= in_data;
              LANE_1:  hold[15:8]  <= in_data;
              LANE_2:  hold[7:0]   <= in_data;
              default: begin
                words_loaded <= wl_inc;
                // Stop short of the top word so waddr never wraps at full depth.
                if (!last_word) waddr <= waddr + DEPTH_LOG2'(1);
              end
            endcase
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  imem_loader_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({hold, in_data}),
    .a     (a),
    .rd    (rd)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic, full-depth, illegal count, timeout,
// gapped stream with a frozen RUN state, and reset in the middle of a load.
module tb_imem_loader;

  localparam int D = 6;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [D-1:0] a = '0;
  logic [31:0]  rd;
  logic         cpu_reset;
  logic         done;
  logic         err;
  logic [D:0]   words_loaded;

  int passed = 0;
  int total  = 0;

  imem_loader #(.DEPTH_LOG2(D), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .rd           (rd),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Offers one byte, waits (bounded) for acceptance, returns #1 after that edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    total++;
    if (!in_ready) $display("FAIL send_byte: in_ready stuck at 0, byte %h not accepted", b);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic check_word(input string name, input logic [D-1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    total++;
    if (rd !== exp) $display("FAIL %s: rd[%0d] got %h expected %h", name, addr, rd, exp);
    else passed++;
  endtask

  task automatic check_status(input string name, input logic exp_ready, input logic exp_cpu_reset,
                              input logic exp_done, input logic exp_err, input logic [D:0] exp_wl);
    total++;
    if ({in_ready, cpu_reset, done, err} !== {exp_ready, exp_cpu_reset, exp_done, exp_err} ||
        words_loaded !== exp_wl) begin
      $display("FAIL %s: ready/cpu_reset/done/err=%b%b%b%b wl=%0d expected %b%b%b%b wl=%0d",
               name, in_ready, cpu_reset, done, err, words_loaded,
               exp_ready, exp_cpu_reset, exp_done, exp_err, exp_wl);
    end else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    check_status("reset_state", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h02);
    send_word(32'h2002_0005);
    send_byte(8'h20);
    send_byte(8'h03);
    send_byte(8'h00);
    check_status("basic_before_last", 1'b1, 1'b1, 1'b0, 1'b0, 7'd1);
    send_byte(8'h0C);
    check_status("basic_after_last", 1'b0, 1'b0, 1'b1, 1'b0, 7'd2);
    check_word("basic_w0", 6'd0, 32'h2002_0005);
    check_word("basic_w1", 6'd1, 32'h2003_000C);
  endtask

  task automatic test_full_depth();
    do_reset();
    send_byte(8'h00);
    for (int k = 0; k < 64; k++) begin
      if (k == 63) check_status("full_before_last", 1'b1, 1'b1, 1'b0, 1'b0, 7'd63);
      send_word(32'h1000_0000 + k);
    end
    check_status("full_done", 1'b0, 1'b0, 1'b1, 1'b0, 7'd64);
    for (int k = 0; k < 64; k++) check_word("full_word", D'(k), 32'h1000_0000 + k);
  endtask

  task automatic test_illegal_count();
    do_reset();
    send_byte(8'h40);
    check_status("count_64_legal", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
    do_reset();
    send_byte(8'h41);
    check_status("count_65_err", 1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
    in_data  = 8'h05;
    in_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_status("err_sticky", 1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
    check_word("err_ram_kept", 6'd0, 32'h1000_0000);
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (T - 1) @(posedge clk);
    #1;
    check_status("timeout_not_yet", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
    @(posedge clk);
    #1;
    check_status("timeout_err", 1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
    check_word("timeout_ram_kept", 6'd0, 32'h1000_0000);
    in_data  = 8'hDD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_word("timeout_no_write", 6'd0, 32'h1000_0000);
  endtask

  task automatic test_back_to_back_gaps();
    logic [31:0] words [3];
    words[0] = 32'hA1B2_C3D4;
    words[1] = 32'h0102_0304;
    words[2] = 32'hCAFE_F00D;
    do_reset();
    send_byte(8'h03);
    for (int w = 0; w < 3; w++) begin
      for (int i = 3; i >= 0; i--) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        send_byte(words[w][i*8 +: 8]);
      end
    end
    check_status("gaps_done", 1'b0, 1'b0, 1'b1, 1'b0, 7'd3);
    for (int w = 0; w < 3; w++) check_word("gaps_word", D'(w), words[w]);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL run_ready: in_ready got %b expected 0", in_ready);
      else passed++;
    end
    in_valid = 1'b0;
    check_status("run_frozen", 1'b0, 1'b0, 1'b1, 1'b0, 7'd3);
    for (int w = 0; w < 3; w++) check_word("run_word", D'(w), words[w]);
    check_word("run_word3", 6'd3, 32'h1000_0003);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h03);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    check_status("midload_idle", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
    check_word("midload_w0", 6'd0, 32'hDEAD_BEEF);
    check_word("midload_w1", 6'd1, 32'h0102_0304);
    send_byte(8'h01);
    send_word(32'h1122_3344);
    check_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b0, 7'd1);
    check_word("reload_w0", 6'd0, 32'h1122_3344);
    check_word("reload_w1", 6'd1, 32'h0102_0304);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_illegal_count();
    test_timeout();
    test_back_to_back_gaps();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream writer for the processor's instruction memory. It holds a 2^DEPTH_LOG2 x 32 instruction RAM, accepts a length-prefixed program image over a valid/ready byte interface, and assembles the bytes into big-endian words. It holds the core in reset until the image is complete. The processor fetches through a combinational read port, so this block replaces the fixed, file-initialised instruction memory in top.

Parameters:
DEPTH_LOG2, 6, log2 of RAM depth in words; legal range 1..8, because the count byte is 8 bits.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes while in LOAD before an error is declared.

Ports:
clk  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a byte this cycle.
a  in  DEPTH_LOG2  fetch word address (the processor drives pc[DEPTH_LOG2+1:2]).
rd  out  32  fetch data, combinational: RAM[a].
cpu_reset  out  1  high while the core must be held in reset.
done  out  1  image fully loaded.
err  out  1  load failed; sticky until reset.
words_loaded  out  DEPTH_LOG2+1  count of words written in the current load.

Behaviour:
- Transfer rule: a byte is accepted on a posedge where in_valid && in_ready. No other byte is consumed.
- in_ready is 1 in IDLE and LOAD, and 0 in RUN and ERROR.
- States: IDLE, LOAD, RUN, ERROR.
- Reset values (next posedge with reset=1):
  - state=IDLE, cpu_reset=1, done=0, err=0, in_ready=1, words_loaded=0.
  - Byte-lane counter, word address and timeout counter all 0.
  - RAM contents are NOT cleared.
- IDLE:
  - The first accepted byte is the word count N.
  - N=0 means the full depth 2^DEPTH_LOG2.
  - If the decoded N is greater than 2^DEPTH_LOG2, go to ERROR. Otherwise latch N and go to LOAD.
  - No timeout is applied in IDLE.
- LOAD, byte assembly:
  - Bytes arrive MSB first (byte0 -> [31:24] ... byte3 -> [7:0]), matching the hex word order of the image file.
  - A 2-bit lane counter tracks position. Lanes 0..2 go to a holding register.
  - On acceptance of lane 3, RAM[waddr] <= {hold[23:0], in_data} on that same edge. waddr then increments and words_loaded increments.
- LOAD, completion:
  - When the word written makes words_loaded == N, go to RUN on the same edge.
  - cpu_reset falls and done rises in the cycle immediately after the last byte is accepted (one-cycle latency).
- LOAD, timeout:
  - The timeout counter clears on every accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES, go to ERROR. A partial word in the holding register is discarded (never written).
- RUN:
  - cpu_reset=0, done=1, in_ready=0.
  - Stream input is ignored and the RAM is frozen.
  - Only reset leaves RUN.
- ERROR: err=1, cpu_reset=1, done=0, in_ready=0. Only reset leaves ERROR.
- Read/write collision: a read of the address being written in the same cycle returns the old data before the edge and the new data after it. No bypass.
- Reset mid-load: return to IDLE. Words already written remain in the RAM. words_loaded returns to 0 and the partial word is discarded.
- Reset during RUN: the core is re-held in reset and a new image is expected.
- Width rules:
  - waddr is DEPTH_LOG2 bits. It never wraps, because the N check bounds it.
  - words_loaded is DEPTH_LOG2+1 bits so that it can represent the full depth.
  - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, RUN, ERROR);
  - the byte-lane index constants;
  - a function decode_count(byte, DEPTH_LOG2) returning the effective N and a legal flag.
- One sub-module: imem_ram, a 2^DEPTH_LOG2 x 32 RAM with one synchronous write port (we, waddr, wdata) and one asynchronous read port (a, rd).
- The FSM, byte assembler and timeout counter stay in imem_loader.

Test Plan:
1. Basic load:
   - Stimulus: stream 02, 20 02 00 05, 20 03 00 0C, gap-free.
   - Response: rd(a=0)=0x20020005 and rd(a=1)=0x2003000C. words_loaded=2. done=1 and cpu_reset=0 exactly one cycle after the last byte. in_ready=0 thereafter.
2. Full depth:
   - Stimulus: count byte 00, then 256 bytes with word k = 0x1000_0000+k.
   - Response: all 64 words correct; words_loaded=64; done=1.
3. Illegal count:
   - Stimulus: count byte 0x41 (65).
   - Response: err=1 on the next cycle, in_ready=0, cpu_reset=1, done=0. Further bytes are ignored.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16. Send 01, AA, BB, CC, then hold in_valid=0.
   - Response: err=1 after 16 idle cycles. RAM[0] is unchanged from its pre-load value.
5. Backpressure and gaps:
   - Stimulus: a 3-word load with in_valid toggling randomly and gaps shorter than the timeout. After done, hold in_valid=1 with data FF for 20 cycles.
   - Response: words are correct. In RUN, RAM is unchanged and no byte is accepted.
6. Reset mid-load:
   - Stimulus: load 03 plus word 0 (0xDEADBEEF) and two bytes of word 1, then pulse reset for one cycle.
   - Response: IDLE, in_ready=1, words_loaded=0, cpu_reset=1, RAM[0]=0xDEADBEEF. A subsequent load of 01, 11 22 33 44 sets RAM[0]=0x11223344 and done=1.
